exception_sequencer: RTL

Multicycle exception front end for the CPU datapath. Detects exception requests from the control unit and ALU/divider, encodes the winning cause into the 2-bit exception code consumed by the exception vector selector (code 0/1/2 → byte address 253/254/255), and sequences the handling steps. Those steps are: save EPC, read the handler byte from the vector address, and load PC with it. Sits between the main control FSM and the PC/EPC/memory-address muxes.

---
 rtl/exception_pkg.sv | 25 ++
 rtl/exception_priority_encoder.sv | 33 +++
 rtl/exception_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/exception_pkg.sv
// rtl/exception_pkg.sv - shared exception codes, vector base and sequencer state type
//
// Purpose: constants and types shared by the exception sequencer and its
// priority encoder.
//   EXC_*        2-bit cause codes consumed by the exception vector selector
//   VECTOR_BASE  byte address of the code-0 vector (code n lives at base+n)
//   state_t      sequencer FSM states
package exception_pkg;

  localparam logic [1:0] EXC_OPCODE   = 2'd0;
  localparam logic [1:0] EXC_OVERFLOW = 2'd1;
  localparam logic [1:0] EXC_DIVZERO  = 2'd2;
  localparam logic [1:0] EXC_NONE     = 2'd3;

  localparam logic [7:0] VECTOR_BASE  = 8'd253;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_FETCH,
    ST_LOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/exception_priority_encoder.sv
// rtl/exception_priority_encoder.sv - fixed-priority encoder for exception requests
//
// Purpose: pick the winning exception request (opcode > overflow > div-zero).
// Ports:
//   opcode_invalid  in   invalid-opcode request
//   overflow        in   arithmetic-overflow request
//   div_zero        in   divide-by-zero request
//   code            out  winning cause code, EXC_NONE when nothing is requested
//   valid           out  high when any request is present
module exception_priority_encoder
  import exception_pkg::*;
(
  input  logic       opcode_invalid,
  input  logic       overflow,
  input  logic       div_zero,
  output logic [1:0] code,
  output logic       valid
);

  always_comb begin
    valid = opcode_invalid | overflow | div_zero;
    if (opcode_invalid) begin
      code = EXC_OPCODE;
    end else if (overflow) begin
      code = EXC_OVERFLOW;
    end else if (div_zero) begin
      code = EXC_DIVZERO;
    end else begin
      code = EXC_NONE;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multicycle exception front end (save EPC, fetch vector, load PC)
//
// Purpose: accept an exception request while idle, latch cause and PC, then
// sequence SAVE -> FETCH (MEM_LATENCY cycles) -> LOAD -> DONE.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   opcode_invalid_i,
//   overflow_i,
//   div_zero_i          exception requests, sampled only in IDLE
//   pc_i                current (already incremented) PC
//   mem_byte_i          handler byte read from the vector address
//   exc_code_o          latched cause from SAVE through LOAD, otherwise 3
//   addr_sel_o          vector address onto memory address mux (FETCH, LOAD)
//   mem_rd_o            memory read strobe (FETCH)
//   epc_we_o, epc_o     EPC write (SAVE), value latched_pc - 4
//   pc_we_o, pc_o       PC write (LOAD), value {24'b0, mem_byte_i}
//   busy_o              high in every non-IDLE state
//   done_o              one-cycle pulse in DONE
module exception_sequencer
  import exception_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        opcode_invalid_i,
  input  logic        overflow_i,
  input  logic        div_zero_i,
  input  logic [31:0] pc_i,
  input  logic [7:0]  mem_byte_i,
  output logic [1:0]  exc_code_o,
  output logic        addr_sel_o,
  output logic        mem_rd_o,
  output logic        epc_we_o,
  output logic [31:0] epc_o,
  output logic        pc_we_o,
  output logic [31:0] pc_o,
  output logic        busy_o,
  output logic        done_o
);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [1:0]  cause_q;
  logic [31:0] pc_q;

  logic [1:0]  req_code;
  logic        req_valid;

  exception_priority_encoder u_prio (
    .opcode_invalid (opcode_invalid_i),
    .overflow       (overflow_i),
    .div_zero       (div_zero_i),
    .code           (req_code),
    .valid          (req_valid)
  );

  // Control outputs are registered alongside the state so each one is a
  // clean decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cause_q    <= EXC_NONE;
      pc_q       <= '0;
      addr_sel_o <= 1'b0;
      mem_rd_o   <= 1'b0;
      epc_we_o   <= 1'b0;
      pc_we_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      epc_we_o <= 1'b0;
      pc_we_o  <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Requests are only looked at here; anything raised while busy is lost.
          if (req_valid) begin
            state    <= ST_SAVE;
            cause_q  <= req_code;
            pc_q     <= pc_i;
            epc_we_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        ST_SAVE: begin
          state      <= ST_FETCH;
          wait_cnt   <= 3'(MEM_LATENCY - 1);
          addr_sel_o <= 1'b1;
          mem_rd_o   <= 1'b1;
        end
        ST_FETCH: begin
          if (wait_cnt == '0) begin
            state    <= ST_LOAD;
            mem_rd_o <= 1'b0;
            pc_we_o  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_LOAD: begin
          state      <= ST_DONE;
          addr_sel_o <= 1'b0;
          cause_q    <= EXC_NONE;
          done_o     <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          cause_q    <= EXC_NONE;
          addr_sel_o <= 1'b0;
          mem_rd_o   <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

  assign exc_code_o = cause_q;
  // Wraps mod 2^32, so a latched PC of 0 gives 0xFFFFFFFC.
  assign epc_o      = epc_we_o ? (pc_q - 32'd4) : 32'd0;
  // The handler byte is taken straight from memory in the LOAD cycle.
  assign pc_o       = pc_we_o ? {24'b0, mem_byte_i} : 32'd0;

endmodule
